tdo_return_packer: RTL

Return path of the XPCU CPLD. It samples TDO on every TCK rising edge of a capturing shift and packs the bits LSB-first into bytes. The bytes are buffered in a small FIFO and offered to the FX2 over the GPIF data bus (fd) with a ready/strobe handshake. It sits beside the JTAG shifter that consumes the GPIF write stream, and returns the readback data that shifter produces.

---
 rtl/xpcu_pkg.sv | 5 +
 rtl/tdo_fifo.sv | 47 ++++
 rtl/tdo_return_packer.sv | 61 ++++++
 3 files changed

// File: rtl/xpcu_pkg.sv
// Constants shared by the XPCU GPIF write-side shifter and the TDO return path.
package xpcu_pkg;
  localparam int BYTE_W     = 8;
  localparam int FIFO_DEPTH = 4;
endpackage

// File: rtl/tdo_fifo.sv
// Byte FIFO for the TDO return path: wrap-bit pointers, sticky overflow, zeroed head when empty.
module tdo_fifo
  import xpcu_pkg::*;
#(
  parameter int DEPTH = FIFO_DEPTH,
  parameter int W     = BYTE_W
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic [W-1:0] push_data,
  input  logic         pop_req,
  output logic [W-1:0] head,
  output logic         empty,
  output logic         ovf
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = (AW + 1)'(1);

  logic [W-1:0] mem [DEPTH];
  logic [AW:0]  wr_ptr, rd_ptr;
  logic         full, pop, wr_en;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign pop   = pop_req && !empty;
  // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
  assign wr_en = push && (!full || pop);
  assign head  = empty ? '0 : mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      ovf    <= 1'b0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop) rd_ptr <= rd_ptr + PTR_ONE;
      if (push && full && !pop) ovf <= 1'b1;
    end
  end

  // Contents need no reset: head is masked to zero while empty.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr[AW-1:0]] <= push_data;
  end
endmodule

// File: rtl/tdo_return_packer.sv
// Packs TDO samples LSB-first into bytes and offers them to the FX2 over the GPIF fd bus.
module tdo_return_packer
  import xpcu_pkg::*;
#(
  parameter int DEPTH = FIFO_DEPTH
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              tck_rise,
  input  logic              tdo,
  input  logic              cap_en,
  input  logic              flush,
  input  logic              rd_strobe,
  input  logic              rd_oe,
  output logic [BYTE_W-1:0] fd_out,
  output logic              fd_oe,
  output logic              rdy,
  output logic              ovf,
  output logic [2:0]        bits_pend
);
  logic [BYTE_W-1:0] sr, sr_nxt;
  logic              cap, byte_done, do_flush, push, empty;

  assign cap       = tck_rise && cap_en;
  assign byte_done = cap && (bits_pend == 3'd7);
  // A capture in the flush cycle counts as pending, so that bit rides along.
  assign do_flush  = flush && ((bits_pend != 3'd0) || cap);
  assign push      = byte_done || do_flush;

  always_comb begin
    sr_nxt = sr;
    if (cap) sr_nxt[bits_pend] = tdo;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sr        <= '0;
      bits_pend <= 3'd0;
    end else if (push) begin
      sr        <= '0;
      bits_pend <= 3'd0;
    end else if (cap) begin
      sr        <= sr_nxt;
      bits_pend <= bits_pend + 3'd1;
    end
  end

  tdo_fifo #(.DEPTH(DEPTH), .W(BYTE_W)) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push),
    .push_data (sr_nxt),
    .pop_req   (rd_strobe),
    .head      (fd_out),
    .empty     (empty),
    .ovf       (ovf)
  );

  assign rdy   = !empty;
  assign fd_oe = rd_oe;
endmodule
